approx_mult_pipe_nxn: RTL and testbench
=======================================

Name: approx_mult_pipe_nxn

Overview:
- Parametrised, pipelined unsigned N×N multiplier with a run-time selectable lower-part approximation.
- Partial-product columns of weight below L are compressed carry-free (column OR). Columns of weight L and above are summed exactly.
- Elastic 2-stage pipeline with valid/ready backpressure, plus a saturating counter of inexact results.
- Sits in the approximate-arithmetic datapath as the registered successor to the fixed 8×8 combinational approximate multipliers.

Parameters:
- N, 8, operand width in bits (N ≥ 2).
- L, 6, approximation boundary; columns 0..L-1 are approximated (0 ≤ L ≤ 2N; L=0 means always exact).
- CNT_W, 16, width of the inexact-result counter.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operand pair this cycle
- x  input  N  unsigned multiplicand
- y  input  N  unsigned multiplier
- approx_en  input  1  1 = approximate mode, 0 = exact; sampled with operands
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- z  output  2N  product (approximate or exact per sampled approx_en)
- z_inexact  output  1  1 when z differs from exact x*y
- err_cnt  output  CNT_W  count of accepted outputs with z_inexact=1, saturating
- err_clr  input  1  synchronous clear of err_cnt

Behaviour:
- Partial products: pp[i][j] = x[i] & y[j], weight i+j.
- Approx result:
  - A_hi = sum over all pp with i+j ≥ L of pp·2^(i+j), exact with full carries, 2N bits.
  - A_lo bit c (c < L) = OR of all pp[i][j] with i+j = c; no carries.
  - z = A_hi + A_lo, truncated to 2N bits (cannot overflow since A ≤ exact).
- Exact result: x*y.
- Guaranteed: approximate z ≤ exact x*y.
- z_inexact = (z != x*y); always 0 when approx_en=0.
- Pipeline:
  - S1 registers x, y, approx_en and the partially reduced high and low terms.
  - S2 registers z and z_inexact.
  - Latency is 2 cycles from handshake acceptance to out_valid with no stall.
- Handshake:
  - Transfer on in_valid & in_ready.
  - Output consumed on out_valid & out_ready.
  - Each stage advances when its successor is empty or being consumed that cycle.
  - in_ready = !S1_valid | S1_advances (combinational from out_ready).
  - Full throughput of 1/cycle when out_ready held high.
  - z and out_valid stay stable while out_valid & !out_ready.
  - No result is dropped or duplicated.
- err_cnt:
  - Increments by 1 on each output handshake with z_inexact=1.
  - Saturates at 2^CNT_W-1.
  - err_clr has priority: on simultaneous clear and increment the result is 0.
- Reset:
  - S1/S2 valid = 0, out_valid = 0, z = 0, z_inexact = 0, err_cnt = 0.
  - in_ready = 1 in the cycle after reset deasserts.
  - Reset mid-operation discards all in-flight data.
- Boundary: L=0 gives exact behaviour regardless of approx_en; L=2N approximates all columns.

Test Plan:
- N=8, L=6, approx_en=1, x=0xFF, y=0xFF, out_ready=1 → after 2 cycles z=0xFCFF (64767), z_inexact=1, err_cnt=1.
- Same operands, approx_en=0 → z=0xFE01, z_inexact=0, err_cnt unchanged.
- Approx_en=1, operand pairs (3,3), (0x80,0x80), (0x21,0x01) back-to-back →
  - z=7, 16384, 33
  - z_inexact=1, 0, 0
  - outputs on 3 consecutive cycles.
- Backpressure: stream 6 operand pairs while toggling out_ready 1,0,0,1,0,1… → in_ready drops when both stages are full; outputs appear in order, z stable during stall, none lost or repeated.
- Counter: CNT_W=4, feed 20 inexact ops → err_cnt saturates at 15. Then assert err_clr together with an inexact output handshake → err_cnt=0.
- Reset with 2 results in flight → out_valid=0, err_cnt=0 next cycle; a new op issued afterwards returns correctly with latency 2.

Source files
------------

// File: rtl/approx_mult_pipe_nxn.sv
// approx_mult_pipe_nxn
// Pipelined unsigned N x N multiplier with a run-time selectable approximation
// of the low partial-product columns. Columns of weight below L are compressed
// carry-free (OR of the column), and columns of weight L and above are summed
// exactly. The pipeline has two elastic stages with valid/ready flow control.
// A saturating counter tracks how many consumed results were inexact.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready depends combinationally on out_ready)
//   x, y                unsigned operands, N bits each
//   approx_en           1 = approximate, 0 = exact; captured with the operands
//   out_valid/out_ready result handshake
//   z                   2N-bit product
//   z_inexact           1 when z differs from the exact x*y
//   err_cnt             saturating count of consumed results with z_inexact=1
//   err_clr             synchronous clear of err_cnt; wins over an increment
module approx_mult_pipe_nxn #(
  parameter int N     = 8,
  parameter int L     = 6,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       x,
  input  logic [N-1:0]       y,
  input  logic               approx_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*N-1:0]     z,
  output logic               z_inexact,
  output logic [CNT_W-1:0]   err_cnt,
  input  logic               err_clr
);

  localparam int W = 2 * N;
  // Columns 0..L-1 are selected by LO_MASK; L >= W selects every column.
  localparam logic [W-1:0] LO_MASK = (L >= W) ? '1 : ((W'(1) << L) - W'(1));
  localparam logic [W-1:0] HI_MASK = ~LO_MASK;

  // Operand-side reduction. Each row i is y gated by x[i], shifted to weight i.
  // The high part of every row joins an exact sum; the low part is ORed, which
  // gives exactly the column-wise OR of the partial products.
  logic [W-1:0] w_row;
  logic [W-1:0] w_hi;
  logic [W-1:0] w_lo;

  always_comb begin
    w_row = '0;
    w_hi  = '0;
    w_lo  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_row = {{N{1'b0}}, (y & {N{x[i]}})} << i;
      w_hi  = w_hi + (w_row & HI_MASK);
      w_lo  = w_lo | (w_row & LO_MASK);
    end
  end

  // Stage 1
  logic               r_s1_valid;
  logic               r_s1_en;
  logic [N-1:0]       r_s1_x;
  logic [N-1:0]       r_s1_y;
  logic [W-1:0]       r_s1_hi;
  logic [W-1:0]       r_s1_lo;

  // Stage 2
  logic               r_s2_valid;
  logic [W-1:0]       r_s2_z;
  logic               r_s2_inexact;

  logic [CNT_W-1:0]   r_err_cnt;

  logic               w_s2_free;
  logic               w_s1_adv;
  logic               w_in_fire;
  logic               w_out_fire;

  assign w_s2_free  = !r_s2_valid || out_ready;
  assign w_s1_adv   = r_s1_valid && w_s2_free;
  assign in_ready   = !r_s1_valid || w_s1_adv;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_s2_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
    end else if (w_in_fire) begin
      r_s1_valid <= 1'b1;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage-1 datapath carries no reset; it is qualified by r_s1_valid.
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_s1_x  <= x;
      r_s1_y  <= y;
      r_s1_en <= approx_en;
      r_s1_hi <= w_hi;
      r_s1_lo <= w_lo;
    end
  end

  // Stage-2 combine: approximate value is hi + lo (lo holds no carries, so the
  // sum stays at or below the exact product and never overflows W bits).
  logic [W-1:0] w_exact;
  logic [W-1:0] w_approx;
  logic [W-1:0] w_z;

  assign w_exact  = {{N{1'b0}}, r_s1_x} * {{N{1'b0}}, r_s1_y};
  assign w_approx = r_s1_hi + r_s1_lo;
  assign w_z      = r_s1_en ? w_approx : w_exact;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid   <= 1'b0;
      r_s2_z       <= '0;
      r_s2_inexact <= 1'b0;
    end else if (w_s1_adv) begin
      r_s2_valid   <= 1'b1;
      r_s2_z       <= w_z;
      r_s2_inexact <= (w_z != w_exact);
    end else if (w_out_fire) begin
      r_s2_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      r_err_cnt <= '0;
    end else if (w_out_fire && r_s2_inexact && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

  assign out_valid = r_s2_valid;
  assign z         = r_s2_z;
  assign z_inexact = r_s2_inexact;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_approx_mult_pipe_nxn.sv
// Testbench for approx_mult_pipe_nxn. The main instance uses N=8, L=6, CNT_W=4;
// two boundary instances (L=0 and L=16) share its inputs and run in lockstep.
// Expected results are pushed to a queue when an operand pair is accepted and
// popped when a result is consumed.
module tb_approx_mult_pipe_nxn;

  localparam int N     = 8;
  localparam int L     = 6;
  localparam int CNT_W = 4;
  localparam int W     = 2 * N;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             in_valid;
  logic             approx_en;
  logic             out_ready;
  logic             err_clr;
  logic [N-1:0]     x;
  logic [N-1:0]     y;

  logic             in_ready,  out_valid,  z_inexact;
  logic [W-1:0]     z;
  logic [CNT_W-1:0] err_cnt;

  logic             in_ready_l0, out_valid_l0, z_inexact_l0;
  logic [W-1:0]     z_l0;
  logic [CNT_W-1:0] err_cnt_l0;

  logic             in_ready_lf, out_valid_lf, z_inexact_lf;
  logic [W-1:0]     z_lf;
  logic [CNT_W-1:0] err_cnt_lf;

  approx_mult_pipe_nxn #(.N(N), .L(L), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .approx_en(approx_en), .out_valid(out_valid),
    .out_ready(out_ready), .z(z), .z_inexact(z_inexact),
    .err_cnt(err_cnt), .err_clr(err_clr)
  );

  approx_mult_pipe_nxn #(.N(N), .L(0), .CNT_W(CNT_W)) u_dut_l0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l0),
    .x(x), .y(y), .approx_en(approx_en), .out_valid(out_valid_l0),
    .out_ready(out_ready), .z(z_l0), .z_inexact(z_inexact_l0),
    .err_cnt(err_cnt_l0), .err_clr(err_clr)
  );

  approx_mult_pipe_nxn #(.N(N), .L(W), .CNT_W(CNT_W)) u_dut_lf (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_lf),
    .x(x), .y(y), .approx_en(approx_en), .out_valid(out_valid_lf),
    .out_ready(out_ready), .z(z_lf), .z_inexact(z_inexact_lf),
    .err_cnt(err_cnt_lf), .err_clr(err_clr)
  );

  int total = 0;
  int bad   = 0;
  int n_out = 0;

  typedef struct {
    logic [W-1:0] z;
    logic         inex;
    logic [W-1:0] z0;
    logic [W-1:0] zf;
    logic         inexf;
  } exp_t;

  exp_t sb[$];

  // Column-count model: count partial products per column; columns below lb
  // contribute a single bit if any product is set, others their full count.
  function automatic logic [W-1:0] model_z(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic en, input int lb);
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int cnt;
    int j;
    hi = '0;
    lo = '0;
    if (!en) return {{N{1'b0}}, a} * {{N{1'b0}}, b};
    for (int c = 0; c < W; c++) begin
      cnt = 0;
      for (int i = 0; i < N; i++) begin
        j = c - i;
        if (j >= 0 && j < N && a[i] && b[j]) cnt++;
      end
      if (c < lb) lo[c] = (cnt != 0);
      else hi = hi + (W'(cnt) << c);
    end
    return hi + lo;
  endfunction

  function automatic exp_t make_exp(input logic [N-1:0] a, input logic [N-1:0] b, input logic en);
    exp_t e;
    logic [W-1:0] ex;
    ex      = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    e.z     = model_z(a, b, en, L);
    e.inex  = (e.z != ex);
    e.z0    = model_z(a, b, en, 0);
    e.zf    = model_z(a, b, en, W);
    e.inexf = (e.zf != ex);
    return e;
  endfunction

  // Scoreboard monitor, sampled on the falling edge (inputs change just after
  // the rising edge, so these are the values the next rising edge will see).
  logic [W-1:0] hold_z;
  logic         hold_inex;
  logic         stalled = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      stalled = 1'b0;
    end else begin
      if (stalled && out_valid) begin
        total++;
        if (z !== hold_z || z_inexact !== hold_inex) begin
          bad++;
          $display("FAIL stall_hold: z=%h inexact=%0b, required z=%h inexact=%0b",
                   z, z_inexact, hold_z, hold_inex);
        end
      end
      stalled = 1'b0;
      if (out_valid && out_ready) begin
        total++;
        n_out++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL extra_output: z=%h appeared, required no output", z);
        end else begin
          e = sb.pop_front();
          if (z !== e.z || z_inexact !== e.inex) begin
            bad++;
            $display("FAIL result: z=%h inexact=%0b, required z=%h inexact=%0b",
                     z, z_inexact, e.z, e.inex);
          end
          if (out_valid_l0 !== 1'b1 || z_l0 !== e.z0 || z_inexact_l0 !== 1'b0 ||
              err_cnt_l0 !== '0 || in_ready_l0 !== in_ready) begin
            bad++;
            $display("FAIL result_l0: valid=%0b z=%h inexact=%0b cnt=%0d, required 1/%h/0/0",
                     out_valid_l0, z_l0, z_inexact_l0, err_cnt_l0, e.z0);
          end
          if (out_valid_lf !== 1'b1 || z_lf !== e.zf || z_inexact_lf !== e.inexf ||
              in_ready_lf !== in_ready) begin
            bad++;
            $display("FAIL result_l16: valid=%0b z=%h inexact=%0b, required 1/%h/%0b",
                     out_valid_lf, z_lf, z_inexact_lf, e.zf, e.inexf);
          end
        end
      end else if (out_valid) begin
        stalled   = 1'b1;
        hold_z    = z;
        hold_inex = z_inexact;
      end
      if (in_valid && in_ready) sb.push_back(make_exp(x, y, approx_en));
    end
  end

  // Called just after a rising edge; returns just after a falling edge.
  task automatic drain(output bit ok);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (sb.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
    approx_en = 1'b0; x = '0; y = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || z !== '0 || z_inexact !== 1'b0 || err_cnt !== '0) begin
      bad++;
      $display("FAIL reset_state: valid=%0b z=%h inexact=%0b cnt=%0d, required 0/0/0/0",
               out_valid, z, z_inexact, err_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: in_ready=%0b, required 1", in_ready);
    end
  endtask

  task automatic test_single_approx;
    @(posedge clk); #1;
    x = 8'hFF; y = 8'hFF; approx_en = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL latency_early: out_valid=%0b, required 0", out_valid);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || z !== 16'hFCFF || z_inexact !== 1'b1) begin
      bad++;
      $display("FAIL single_approx: valid=%0b z=%h inexact=%0b, required 1/fcff/1",
               out_valid, z, z_inexact);
    end
    @(negedge clk);
    total++;
    if (err_cnt !== 4'd1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_cnt: cnt=%0d valid=%0b, required 1/0", err_cnt, out_valid);
    end
  endtask

  task automatic test_exact_mode;
    @(posedge clk); #1;
    x = 8'hFF; y = 8'hFF; approx_en = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || z !== 16'hFE01 || z_inexact !== 1'b0) begin
      bad++;
      $display("FAIL exact_mode: valid=%0b z=%h inexact=%0b, required 1/fe01/0",
               out_valid, z, z_inexact);
    end
    @(negedge clk);
    total++;
    if (err_cnt !== 4'd1) begin
      bad++;
      $display("FAIL exact_cnt: cnt=%0d, required 1", err_cnt);
    end
  endtask

  task automatic test_back_to_back;
    logic [N-1:0] ax [3] = '{8'h03, 8'h80, 8'h21};
    logic [N-1:0] ay [3] = '{8'h03, 8'h80, 8'h01};
    logic [5:0]   pattern;
    logic         ready_ok;
    pattern  = '0;
    ready_ok = 1'b1;
    approx_en = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (k < 3) begin
        x = ax[k]; y = ay[k]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      pattern[k] = out_valid;
      if (k < 3 && in_ready !== 1'b1) ready_ok = 1'b0;
    end
    total++;
    if (pattern !== 6'b011100) begin
      bad++;
      $display("FAIL b2b_timing: out_valid pattern=%b, required 011100", pattern);
    end
    total++;
    if (ready_ok !== 1'b1) begin
      bad++;
      $display("FAIL b2b_ready: in_ready dropped=%0b, required held 1", !ready_ok);
    end
  endtask

  task automatic test_backpressure;
    logic [N-1:0] bx [6] = '{8'hFF, 8'h03, 8'h80, 8'h21, 8'h5A, 8'hC3};
    logic [N-1:0] by [6] = '{8'hFF, 8'h03, 8'h80, 8'h01, 8'hA7, 8'h3C};
    logic         orp [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int  idx;
    int  out0;
    bit  saw_full;
    bit  ok;
    idx = 0;
    saw_full = 1'b0;
    out0 = n_out;
    approx_en = 1'b1;
    for (int cyc = 0; cyc < 60 && idx < 6; cyc++) begin
      @(posedge clk); #1;
      out_ready = orp[cyc % 6];
      x = bx[idx]; y = by[idx]; in_valid = 1'b1;
      @(negedge clk);
      if (!in_ready) saw_full = 1'b1;
      if (in_ready) idx++;
    end
    @(posedge clk); #1;
    drain(ok);
    total++;
    if (!ok || idx != 6) begin
      bad++;
      $display("FAIL bp_drain: accepted=%0d pending=%0d, required 6/0", idx, sb.size());
    end
    total++;
    if (n_out - out0 != 6) begin
      bad++;
      $display("FAIL bp_count: outputs=%0d, required 6", n_out - out0);
    end
    total++;
    if (!saw_full) begin
      bad++;
      $display("FAIL bp_ready: in_ready never dropped, required a drop when both stages full");
    end
  endtask

  task automatic test_counter_sat;
    bit ok;
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; x = 8'h03; y = 8'h03; approx_en = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    drain(ok);
    total++;
    if (!ok || err_cnt !== 4'd15 || err_cnt_lf !== 4'd15) begin
      bad++;
      $display("FAIL cnt_sat: drained=%0b cnt=%0d cnt_l16=%0d, required 1/15/15",
               ok, err_cnt, err_cnt_lf);
    end
    @(posedge clk); #1;
    x = 8'h03; y = 8'h03; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || z_inexact !== 1'b1 || err_cnt !== 4'd15) begin
      bad++;
      $display("FAIL clr_setup: valid=%0b inexact=%0b cnt=%0d, required 1/1/15",
               out_valid, z_inexact, err_cnt);
    end
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(negedge clk);
    total++;
    if (err_cnt !== 4'd0) begin
      bad++;
      $display("FAIL clr_priority: cnt=%0d, required 0", err_cnt);
    end
  endtask

  task automatic test_reset_inflight;
    bit ok;
    @(posedge clk); #1;
    x = 8'hFF; y = 8'hFF; approx_en = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    drain(ok);
    total++;
    if (!ok || err_cnt !== 4'd1) begin
      bad++;
      $display("FAIL rst_pre: drained=%0b cnt=%0d, required 1/1", ok, err_cnt);
    end
    @(posedge clk); #1;
    out_ready = 1'b0; x = 8'h03; y = 8'h03; in_valid = 1'b1;
    @(posedge clk); #1;
    x = 8'h80; y = 8'h80;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_inflight: valid=%0b in_ready=%0b, required 1/0", out_valid, in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || err_cnt !== '0 || z !== '0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_flush: valid=%0b cnt=%0d z=%h in_ready=%0b, required 0/0/0/1",
               out_valid, err_cnt, z, in_ready);
    end
    @(posedge clk); #1;
    x = 8'h21; y = 8'h01; out_ready = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_after_early: out_valid=%0b, required 0", out_valid);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || z !== 16'd33 || z_inexact !== 1'b0) begin
      bad++;
      $display("FAIL rst_after_op: valid=%0b z=%0d inexact=%0b, required 1/33/0",
               out_valid, z, z_inexact);
    end
    @(posedge clk); #1;
    drain(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL rst_after_drain: pending=%0d, required 0", sb.size());
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
    approx_en = 1'b0; x = '0; y = '0;
    test_reset();
    test_single_approx();
    test_exact_mode();
    test_back_to_back();
    test_backpressure();
    test_counter_sat();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
